dual_half_convergence_controller: RTL and testbench

- Master stage sequencer for a decoder split into a left half and a right half (two FPGAs or two grid partitions).
- Drives one stage code to both halves. Combines local and remote status flags (messages still flying, odd clusters remaining) to decide when each merge is quiescent and when decoding has converged.
- Reports iteration count, cycle count, deadlock and result_valid to the test bench / host.

---
 rtl/dual_half_convergence_controller.sv | 117 +++++++++++
 tb/tb_dual_half_convergence_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_half_convergence_controller.sv
// Master stage sequencer for a decoder split across two halves.
// Combines local/remote busy and odd-cluster flags into merge quiescence and convergence decisions.
module dual_half_convergence_controller #(
  parameter int CODE_DISTANCE_X         = 3,
  parameter int CODE_DISTANCE_Z         = 3,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int STAGE_WIDTH             = 3,
  parameter int LINK_LATENCY            = 2,
  parameter int MAX_ITERATIONS          = 2 * ((CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                               CODE_DISTANCE_X : CODE_DISTANCE_Z),
  parameter int MERGE_TIMEOUT           = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_round_start,
  input  logic                               has_message_flying_local,
  input  logic                               has_message_flying_remote,
  input  logic                               has_odd_clusters_local,
  input  logic                               has_odd_clusters_remote,
  output logic [STAGE_WIDTH-1:0]             stage,
  output logic                               result_valid,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic [31:0]                        cycle_counter,
  output logic                               deadlock
);

  localparam int QW = $clog2(LINK_LATENCY + 3);
  localparam int MW = $clog2(MERGE_TIMEOUT + 1);
  localparam int IW = ITERATION_COUNTER_WIDTH;

  localparam logic [STAGE_WIDTH-1:0] S_IDLE  = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] S_LOAD  = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] S_GROW  = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] S_MERGE = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] S_DONE  = STAGE_WIDTH'(4);

  // quiet_cnt holds quiet cycles already seen, so exit fires on the (LINK_LATENCY+2)th one
  localparam logic [QW-1:0] QUIET_EXIT   = QW'(LINK_LATENCY + 1);
  localparam logic [MW-1:0] TIMEOUT_LAST = MW'(MERGE_TIMEOUT - 1);
  localparam logic [IW-1:0] MAX_ITER     = IW'(MAX_ITERATIONS);

  logic [STAGE_WIDTH-1:0] state_q, state_d;
  logic [QW-1:0]          quiet_cnt;
  logic [MW-1:0]          merge_cnt;

  logic quiet, quiet_done, timeout, odd, iter_ok, go_deadlock, active;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (new_round_start) state_d = S_LOAD;
      S_LOAD:  state_d = S_GROW;
      S_GROW:  state_d = S_MERGE;
      S_MERGE: begin
        if (timeout)         state_d = S_DONE;
        else if (quiet_done) state_d = (odd && iter_ok) ? S_GROW : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output / decision logic
  always_comb begin
    stage       = state_q;
    active      = (state_q == S_LOAD) || (state_q == S_GROW) || (state_q == S_MERGE);
    quiet       = ~(has_message_flying_local | has_message_flying_remote);
    quiet_done  = (state_q == S_MERGE) && quiet && (quiet_cnt == QUIET_EXIT);
    timeout     = (state_q == S_MERGE) && (merge_cnt == TIMEOUT_LAST);
    odd         = has_odd_clusters_local | has_odd_clusters_remote;
    iter_ok     = iteration_counter < MAX_ITER;
    go_deadlock = timeout || (quiet_done && odd && !iter_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid      <= 1'b0;
      deadlock          <= 1'b0;
      iteration_counter <= '0;
      cycle_counter     <= '0;
      quiet_cnt         <= '0;
      merge_cnt         <= '0;
    end else begin
      if (active && (cycle_counter != '1))
        cycle_counter <= cycle_counter + 32'd1;
      case (state_q)
        S_IDLE: if (new_round_start) begin
          result_valid      <= 1'b0;
          deadlock          <= 1'b0;
          iteration_counter <= '0;
          cycle_counter     <= '0;
        end
        S_GROW: begin
          if (iteration_counter != '1)
            iteration_counter <= iteration_counter + 1'b1;
          quiet_cnt <= '0;
          merge_cnt <= '0;
        end
        S_MERGE: begin
          quiet_cnt <= quiet ? quiet_cnt + 1'b1 : '0;
          merge_cnt <= merge_cnt + 1'b1;
          if (go_deadlock)        deadlock     <= 1'b1;
          if (state_d == S_DONE)  result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_half_convergence_controller.sv
// Directed bench for dual_half_convergence_controller: two instances, default and short merge timeout.
module tb_dual_half_convergence_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        fly_l = 1'b0, fly_r = 1'b0, odd_l = 1'b0, odd_r = 1'b0;
  logic [2:0]  stage_a, stage_b;
  logic        rv_a, rv_b, dl_a, dl_b;
  logic [7:0]  iter_a, iter_b;
  logic [31:0] cyc_a, cyc_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dual_half_convergence_controller dut_a (
    .clk(clk), .reset(reset), .new_round_start(start_a),
    .has_message_flying_local(fly_l), .has_message_flying_remote(fly_r),
    .has_odd_clusters_local(odd_l), .has_odd_clusters_remote(odd_r),
    .stage(stage_a), .result_valid(rv_a), .iteration_counter(iter_a),
    .cycle_counter(cyc_a), .deadlock(dl_a));

  dual_half_convergence_controller #(.MERGE_TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .new_round_start(start_b),
    .has_message_flying_local(fly_l), .has_message_flying_remote(fly_r),
    .has_odd_clusters_local(odd_l), .has_odd_clusters_remote(odd_r),
    .stage(stage_b), .result_valid(rv_b), .iteration_counter(iter_b),
    .cycle_counter(cyc_b), .deadlock(dl_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one round to IDLE; mode: 0 static flags, 1 remote-busy toggle, 2 remote odd for 2 merges,
  // 3 local odd stuck, 4 local busy stuck with a stray start pulse in MERGE (dut_b).
  task automatic run_round(input int mode, output int grows, output int last_mlen,
                           output bit ok);
    int mlen = 0, midx = 0;
    logic [2:0] st, prev = 3'd0;
    grows = 0; ok = 1'b0;
    if (mode == 4) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0; start_b = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      st = (mode == 4) ? stage_b : stage_a;
      if (st == 3'd0) begin ok = 1'b1; break; end
      if (st == 3'd2) grows++;
      if (st == 3'd3) begin
        if (prev != 3'd3) begin midx++; mlen = 0; end
        mlen++;
      end
      if (mode == 1) fly_r = (st == 3'd3) && (mlen <= 20) && (mlen % 3 == 2);
      if (mode == 2) odd_r = (st == 3'd3) && (midx <= 2);
      if (mode == 4) start_b = (st == 3'd3) && (mlen == 5);
      prev = st;
      step();
    end
    start_b = 1'b0;
    last_mlen = mlen;
  endtask

  task automatic test_reset();
    if (stage_a !== 3'd0) $display("FAIL reset_stage: got %0d want 0", stage_a); else n_pass++;
    n_total++;
    if (rv_a !== 1'b0) $display("FAIL reset_rv: got %0d want 0", rv_a); else n_pass++;
    n_total++;
    if (dl_a !== 1'b0) $display("FAIL reset_dl: got %0d want 0", dl_a); else n_pass++;
    n_total++;
    if (iter_a !== 8'd0) $display("FAIL reset_iter: got %0d want 0", iter_a); else n_pass++;
    n_total++;
    if (cyc_a !== 32'd0) $display("FAIL reset_cyc: got %0d want 0", cyc_a); else n_pass++;
    n_total++;
  endtask

  task automatic test_single_pass();
    logic [2:0] exp_seq [8] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (stage_a !== exp_seq[i])
        $display("FAIL single_stage[%0d]: got %0d want %0d", i, stage_a, exp_seq[i]);
      else n_pass++;
      n_total++;
      if (i < 7) step();
    end
    if (rv_a !== 1'b1) $display("FAIL single_rv: got %0d want 1", rv_a); else n_pass++;
    n_total++;
    if (iter_a !== 8'd1) $display("FAIL single_iter: got %0d want 1", iter_a); else n_pass++;
    n_total++;
    if (cyc_a !== 32'd6) $display("FAIL single_cyc: got %0d want 6", cyc_a); else n_pass++;
    n_total++;
    if (dl_a !== 1'b0) $display("FAIL single_dl: got %0d want 0", dl_a); else n_pass++;
    n_total++;
  endtask

  task automatic test_remote_odd();
    int g, ml; bit ok;
    run_round(2, g, ml, ok);
    odd_r = 1'b0;
    if (!ok) $display("FAIL odd_r_done: round did not finish within budget"); else n_pass++;
    n_total++;
    if (g !== 3) $display("FAIL odd_r_grows: got %0d want 3", g); else n_pass++;
    n_total++;
    if (iter_a !== 8'd3) $display("FAIL odd_r_iter: got %0d want 3", iter_a); else n_pass++;
    n_total++;
    if (rv_a !== 1'b1 || dl_a !== 1'b0)
      $display("FAIL odd_r_flags: got rv=%0d dl=%0d want rv=1 dl=0", rv_a, dl_a);
    else n_pass++;
    n_total++;
    if (cyc_a !== 32'd16) $display("FAIL odd_r_cyc: got %0d want 16", cyc_a); else n_pass++;
    n_total++;
  endtask

  task automatic test_quiet_window();
    int g, ml; bit ok;
    run_round(1, g, ml, ok);
    fly_r = 1'b0;
    if (!ok) $display("FAIL quiet_done: round did not finish within budget"); else n_pass++;
    n_total++;
    if (ml !== 24) $display("FAIL quiet_merge_len: got %0d want 24", ml); else n_pass++;
    n_total++;
    if (cyc_a !== 32'd26) $display("FAIL quiet_cyc: got %0d want 26", cyc_a); else n_pass++;
    n_total++;
    if (dl_a !== 1'b0) $display("FAIL quiet_dl: got %0d want 0", dl_a); else n_pass++;
    n_total++;
  endtask

  task automatic test_iteration_limit();
    int g, ml; bit ok;
    odd_l = 1'b1;
    run_round(3, g, ml, ok);
    odd_l = 1'b0;
    if (!ok) $display("FAIL iterlim_done: round did not finish within budget"); else n_pass++;
    n_total++;
    if (g !== 6) $display("FAIL iterlim_grows: got %0d want 6", g); else n_pass++;
    n_total++;
    if (dl_a !== 1'b1 || rv_a !== 1'b1)
      $display("FAIL iterlim_flags: got rv=%0d dl=%0d want rv=1 dl=1", rv_a, dl_a);
    else n_pass++;
    n_total++;
    if (iter_a !== 8'd6) $display("FAIL iterlim_iter: got %0d want 6", iter_a); else n_pass++;
    n_total++;
    if (cyc_a !== 32'd31) $display("FAIL iterlim_cyc: got %0d want 31", cyc_a); else n_pass++;
    n_total++;
  endtask

  task automatic test_timeout();
    int g, ml; bit ok;
    fly_l = 1'b1;
    run_round(4, g, ml, ok);
    fly_l = 1'b0;
    if (!ok) $display("FAIL timeout_done: round did not finish within budget"); else n_pass++;
    n_total++;
    if (ml !== 16) $display("FAIL timeout_merge_len: got %0d want 16", ml); else n_pass++;
    n_total++;
    if (dl_b !== 1'b1 || rv_b !== 1'b1)
      $display("FAIL timeout_flags: got rv=%0d dl=%0d want rv=1 dl=1", rv_b, dl_b);
    else n_pass++;
    n_total++;
    if (cyc_b !== 32'd18) $display("FAIL timeout_cyc: got %0d want 18", cyc_b); else n_pass++;
    n_total++;
    step();
    if (stage_b !== 3'd0 || rv_b !== 1'b1)
      $display("FAIL timeout_hold: got stage=%0d rv=%0d want stage=0 rv=1", stage_b, rv_b);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_mid_round();
    int midx = 0, g, ml; bit ok;
    logic [2:0] prev = 3'd0;
    odd_r = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 100 && midx < 2; c++) begin
      if (stage_a == 3'd3 && prev != 3'd3) midx++;
      prev = stage_a;
      if (midx < 2) step();
    end
    if (midx !== 2) $display("FAIL midreset_reach: merges seen %0d want 2", midx); else n_pass++;
    n_total++;
    step();
    #1 reset = 1'b1;
    #1;
    if (stage_a !== 3'd0 || iter_a !== 8'd0 || cyc_a !== 32'd0 || rv_a !== 1'b0 || dl_a !== 1'b0)
      $display("FAIL midreset_async: got stage=%0d iter=%0d cyc=%0d rv=%0d dl=%0d want all 0",
               stage_a, iter_a, cyc_a, rv_a, dl_a);
    else n_pass++;
    n_total++;
    #1 reset = 1'b0;
    odd_r = 1'b0;
    step();
    run_round(0, g, ml, ok);
    if (!ok || g !== 1 || iter_a !== 8'd1 || cyc_a !== 32'd6 || rv_a !== 1'b1 || dl_a !== 1'b0)
      $display("FAIL midreset_clean: got ok=%0d grows=%0d iter=%0d cyc=%0d rv=%0d dl=%0d want 1,1,1,6,1,0",
               ok, g, iter_a, cyc_a, rv_a, dl_a);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    step();
    step();
    #1 reset = 1'b0;
    step();
    test_reset();
    test_single_pass();
    step();
    test_remote_odd();
    step();
    test_quiet_window();
    step();
    test_iteration_limit();
    step();
    test_timeout();
    step();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
